rdalign: RTL and testbench

RDALIGN -- requirements
Module: rdalign

---
 rtl/rdalign_pkg.sv | 48 ++++
 rtl/rdalign_if.sv | 25 ++
 rtl/rdalign_lanesel.sv | 20 ++
 rtl/rdalign.sv | 112 +++++++++++
 tb/tb_rdalign.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rdalign_pkg.sv
// Shared encodings, state enum and size helpers for the read-data aligner.
package rdalign_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned BYTES  = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        SZ_8  = 2'd0,
        SZ_16 = 2'd1,
        SZ_32 = 2'd2,
        SZ_64 = 2'd3
    } width_e;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    // log2 of the per-beat unit: min(size, bus width)
    function automatic logic [1:0] log2_unit(input width_e siz, input width_e bwid);
        return (siz < bwid) ? 2'(siz) : 2'(bwid);
    endfunction

    function automatic logic [CNT_W-1:0] size_bytes(input width_e siz);
        return 4'd1 << 2'(siz);
    endfunction

    function automatic logic [CNT_W-1:0] unit_bytes(input width_e siz, input width_e bwid);
        return 4'd1 << log2_unit(siz, bwid);
    endfunction

    function automatic logic [CNT_W-1:0] beat_count(input width_e siz, input width_e bwid);
        logic [1:0] l2;
        l2 = log2_unit(siz, bwid);
        return 4'd1 << (2'(siz) - l2);
    endfunction

    // Natural alignment: clear address bits below log2(size bytes)
    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr,
                                                     input width_e siz);
        logic [ADDR_W-1:0] m;
        m = 3'(size_bytes(siz) - 4'd1);
        return addr & ~m;
    endfunction

endpackage

// File: rtl/rdalign_if.sv
// Request/beat/response signal bundle between a bus read master and rdalign.
interface rdalign_if;

    logic                                start;
    logic [rdalign_pkg::ADDR_W-1:0]      addr;
    logic [1:0]                          siz;
    logic [1:0]                          bwid;
    logic [rdalign_pkg::DATA_W-1:0]      din;
    logic                                dack;
    logic [rdalign_pkg::DATA_W-1:0]      dout;
    logic                                done;
    logic                                busy;
    logic [rdalign_pkg::ADDR_W-1:0]      baddr;

    modport master (
        output start, addr, siz, bwid, din, dack,
        input  dout, done, busy, baddr
    );

    modport slave (
        input  start, addr, siz, bwid, din, dack,
        output dout, done, busy, baddr
    );

endinterface

// File: rtl/rdalign_lanesel.sv
// Rotates raw bus data down by a byte address and keeps only the low unit bytes.
module rdalign_lanesel
    import rdalign_pkg::*;
(
    input  logic [DATA_W-1:0] i_din,
    input  logic [ADDR_W-1:0] i_baddr,
    input  logic [CNT_W-1:0]  i_unit,
    output logic [DATA_W-1:0] o_lane_c
);

    always_comb begin
        o_lane_c = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (4'(b) < i_unit) begin
                o_lane_c[8*b +: 8] = i_din[{3'(b) + i_baddr, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/rdalign.sv
// Read-side aligner: steers narrow bus lanes to bit 0 and packs multi-beat reads.
module rdalign
    import rdalign_pkg::*;
(
    input  logic       clk,
    input  logic       resetl,
    rdalign_if.slave   bus
);

    state_e              r_state, w_state_nxt;
    width_e              r_siz, w_siz_nxt;
    width_e              r_bwid, w_bwid_nxt;
    logic [ADDR_W-1:0]   r_baddr, w_baddr_nxt;
    logic [ADDR_W-1:0]   r_off, w_off_nxt;
    logic [CNT_W-1:0]    r_beat, w_beat_nxt;
    logic [DATA_W-1:0]   r_acc, w_acc_nxt;
    logic [DATA_W-1:0]   r_dout, w_dout_nxt;
    logic                r_done, w_done_nxt;
    logic                r_busy, w_busy_nxt;

    logic [CNT_W-1:0]    w_unit;
    logic [CNT_W-1:0]    w_nbeats;
    logic [DATA_W-1:0]   w_lane;
    logic [DATA_W-1:0]   w_placed;

    assign w_unit   = unit_bytes(r_siz, r_bwid);
    assign w_nbeats = beat_count(r_siz, r_bwid);

    rdalign_lanesel u_lanesel (
        .i_din    (bus.din),
        .i_baddr  (r_baddr),
        .i_unit   (w_unit),
        .o_lane_c (w_lane)
    );

    // Beat k lands at accumulator byte offset k*U, tracked directly in r_off
    assign w_placed = w_lane << {r_off, 3'b000};

    always_comb begin
        w_state_nxt = r_state;
        w_siz_nxt   = r_siz;
        w_bwid_nxt  = r_bwid;
        w_baddr_nxt = r_baddr;
        w_off_nxt   = r_off;
        w_beat_nxt  = r_beat;
        w_acc_nxt   = r_acc;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_siz_nxt   = width_e'(bus.siz);
                    w_bwid_nxt  = width_e'(bus.bwid);
                    w_baddr_nxt = align_addr(bus.addr, width_e'(bus.siz));
                    w_off_nxt   = '0;
                    w_beat_nxt  = '0;
                    w_acc_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.dack) begin
                    w_acc_nxt   = r_acc | w_placed;
                    w_baddr_nxt = r_baddr + 3'(w_unit);
                    w_off_nxt   = r_off + 3'(w_unit);
                    w_beat_nxt  = r_beat + 4'd1;
                    if (r_beat == w_nbeats - 4'd1) begin
                        w_dout_nxt  = r_acc | w_placed;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_state <= IDLE;
            r_siz   <= SZ_8;
            r_bwid  <= SZ_8;
            r_baddr <= '0;
            r_off   <= '0;
            r_beat  <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_siz   <= w_siz_nxt;
            r_bwid  <= w_bwid_nxt;
            r_baddr <= w_baddr_nxt;
            r_off   <= w_off_nxt;
            r_beat  <= w_beat_nxt;
            r_acc   <= w_acc_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bus.dout  = r_dout;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
    assign bus.baddr = r_baddr;

endmodule

// File: tb/tb_rdalign.sv
// Scoreboard bench for rdalign: random and directed reads against a byte-level model.
module tb_rdalign;

    typedef struct {
        logic [63:0] dout;
        int          cyc;
    } exp_t;

    logic clk;
    logic resetl;
    rdalign_if bus ();

    rdalign dut (
        .clk    (clk),
        .resetl (resetl),
        .bus    (bus)
    );

    int          checks;
    int          failures;
    int          cyc;
    exp_t        sb[$];
    logic [63:0] last_dout;
    int          last_baddr;
    logic [63:0] fixed_din[8];
    bit          use_fixed;
    int          max_gap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done must match the oldest expectation, in dout and in cycle
    always @(negedge clk) begin
        if (resetl) begin
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_dout", bus.dout, e.dout);
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("done_missing", 64'(bus.done), 64'd1);
            end
        end
    end

    // One complete read; entered and left on a falling edge
    task automatic xfer(input int siz, input int bwid, input int addr);
        int          sz, u, n, a, g;
        logic [63:0] d, exp;
        sz  = 1 << siz;
        u   = (siz < bwid) ? sz : (1 << bwid);
        n   = sz / u;
        a   = addr - (addr % sz);
        exp = '0;
        bus.start = 1'b1;
        bus.siz   = 2'(siz);
        bus.bwid  = 2'(bwid);
        bus.addr  = 3'(addr);
        bus.dack  = 1'($urandom_range(0, 1));
        bus.din   = {$urandom, $urandom};
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        for (int k = 0; k < n; k++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                bus.dack  = 1'b0;
                bus.start = 1'($urandom_range(0, 1));
                bus.siz   = 2'($urandom_range(0, 3));
                bus.addr  = 3'($urandom_range(0, 7));
                bus.din   = {$urandom, $urandom};
                @(negedge clk);
            end
            chk("baddr_beat", 64'(bus.baddr), 64'((a + k * u) % 8));
            d = use_fixed ? fixed_din[k] : {$urandom, $urandom};
            bus.din   = d;
            bus.dack  = 1'b1;
            bus.start = 1'($urandom_range(0, 1));
            for (int b = 0; b < u; b++)
                exp[8*(k*u+b) +: 8] = d[8*((a + k*u + b) % 8) +: 8];
            if (k == n - 1) sb.push_back('{exp, cyc + 1});
            @(negedge clk);
        end
        bus.dack  = 1'b0;
        bus.start = 1'b0;
        chk("busy_in_done", 64'(bus.busy), 64'd0);
        last_dout  = exp;
        last_baddr = (a + n * u) % 8;
    endtask

    // IDLE cycles with stray dack pulses that must not disturb anything
    task automatic idle(input int cycles);
        repeat (cycles) begin
            bus.start = 1'b0;
            bus.dack  = 1'($urandom_range(0, 1));
            bus.din   = {$urandom, $urandom};
            @(negedge clk);
            chk("idle_dout", bus.dout, last_dout);
            chk("idle_baddr", 64'(bus.baddr), 64'(last_baddr));
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        use_fixed = 1'b0; max_gap = 0;
        last_dout = '0; last_baddr = 0;
        bus.start = 1'b0; bus.addr = '0; bus.siz = '0; bus.bwid = '0;
        bus.din = '0; bus.dack = 1'b0;
        resetl = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout", bus.dout, 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_baddr", 64'(bus.baddr), 64'd0);
        resetl = 1'b1;
        @(negedge clk);

        // Single byte from a 64-bit bus
        use_fixed = 1'b1;
        fixed_din[0] = 64'h0011223344556677;
        xfer(0, 3, 5);
        chk("byte_lane5", bus.dout, 64'h0000000000000022);
        idle(2);

        // 32-bit over 16-bit bus, two beats
        fixed_din[0] = 64'h0000BEEF00000000;
        fixed_din[1] = 64'hCAFE000000000000;
        xfer(2, 1, 4);
        chk("word_2beat", bus.dout, 64'h00000000CAFEBEEF);
        idle(2);

        // 64-bit over 8-bit bus, misaligned address forced to zero
        for (int k = 0; k < 8; k++) fixed_din[k] = 64'(8'h10 + k) << (8 * k);
        xfer(3, 0, 3);
        chk("dword_8beat", bus.dout, 64'h1716151413121110);
        idle(3);

        // Full-width passthrough
        fixed_din[0] = {$urandom, $urandom};
        xfer(3, 3, 6);
        chk("passthrough", bus.dout, fixed_din[0]);
        use_fixed = 1'b0;
        idle(1);

        // Reset in the middle of a 4-beat transfer
        bus.start = 1'b1; bus.siz = 2'd3; bus.bwid = 2'd1; bus.addr = 3'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) begin
            bus.dack = 1'b1; bus.din = {$urandom, $urandom};
            @(negedge clk);
        end
        bus.dack = 1'b0;
        #2 resetl = 1'b0;
        #1;
        chk("midrst_dout", bus.dout, 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_baddr", 64'(bus.baddr), 64'd0);
        @(negedge clk);
        resetl = 1'b1;
        last_dout = '0; last_baddr = 0;
        idle(2);
        xfer(3, 1, 0);

        // Back-to-back: new start in the done cycle
        xfer(3, 1, 2);
        xfer(1, 3, 3);
        idle(1);

        // Randomised traffic with gaps and back-to-back starts
        max_gap = 2;
        for (int t = 0; t < 200; t++) begin
            xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)));
            idle(int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
